mil_spi_dispatch: RTL and testbench
===================================

// Module: mil_spi_dispatch
// PURPOSE
// Multi-channel command dispatcher between the SPI communication block and per-channel ring buffers.
// - Decodes packet headers and routes SPI payload into the selected TX ring.
// - Streams a status block or RX ring contents back to SPI.
// - Wraps every access in open/commit/rollback transactions.
// - Generalises the single-pair core to NCH MIL channels, adds transaction rollback and a busy error.
// PARAMETERS
// BLOCK_ADDR 8'hAB  module address; headers with other cmd_addr are ignored
// NCH        2      number of MIL channels (1..8); CH_W = $clog2(NCH) min 1
// WIDTH      16     data word width
// CNT_W      16     ring used-count width, CNT_W <= WIDTH
// PORTS
// clk         in  1            clock
// rst         in  1            reset, synchronous, active-high
// cmd_valid   in  1            1-cycle header strobe; qualifies cmd_addr/code/chan
// cmd_addr    in  8            module address from header
// cmd_code    in  TCommandCode ServiceProtocol command code
// cmd_chan    in  CH_W         target channel
// cmd_done    in  1            1-cycle end-of-packet strobe, packet good
// cmd_abort   in  1            1-cycle end-of-packet strobe, packet bad
// in_valid/in_ready/in_data   in/out/in  1/1/WIDTH     SPI payload stream
// tx_valid/tx_ready           out/in     NCH/NCH       per-channel TX ring push
// tx_data                     out        WIDTH         shared TX push data
// tx_open/tx_commit/tx_rollback  out     NCH each      TX ring transaction control
// tx_used                     in  NCH*CNT_W            TX ring fill levels
// rx_valid/rx_data            in  NCH/NCH*WIDTH        RX ring head
// rx_pop                      out NCH                  RX ring pop
// rx_open/rx_commit/rx_rollback  out     NCH each      RX ring transaction control
// rx_used                     in  NCH*CNT_W            RX ring fill levels
// out_valid/out_ready/out_data   out/in/out  1/1/WIDTH  stream to SPI transmitter
// spi_tx_size   out CNT_W      words SPI will transmit, latched per command
// spi_tx_en     out 1          SPI transmit enable
// reset_request out 1          sticky until rst
// err_busy      out 1          1-cycle pulse: cmd_valid seen while not IDLE
// BEHAVIOUR
// Reset: FSM=IDLE; all outputs 0 except in_ready=1; reset_request=0.
// Header acceptance (IDLE only):
//   - cmd_valid with cmd_addr==BLOCK_ADDR and cmd_chan<NCH latches code/chan.
//   - Otherwise treated as UNKNOWN: stay IDLE.
// IDLE: in_ready=1; payload words are dropped.
// Dispatch on the cycle after acceptance, by command:
//   - TCC_RESET: reset_request<=1 (sticky); stay IDLE.
//   - TCC_SEND_DATA -> SEND; tx_open[ch] pulses 1 cycle on entry.
//   - TCC_RECEIVE_STS -> STS; spi_tx_size=2*NCH; idx=0.
//   - TCC_RECEIVE_DATA -> RDATA; spi_tx_size=rem=rx_used[ch], sampled at acceptance; rx_open[ch] pulses on entry.
//   - Any other code: ignored, stay IDLE.
// SEND:
//   - tx_valid[ch]=in_valid; in_ready=tx_ready[ch]; tx_data=in_data, combinational.
//   - cmd_done -> DONE, tx_commit[ch]. cmd_abort -> DONE, tx_rollback[ch].
//   - A handshake in the same cycle as cmd_done/abort is still pushed, before the commit or rollback.
// STS:
//   - spi_tx_en=1; out_valid=1 while idx<2*NCH.
//   - Word 2k = tx_used[k], word 2k+1 = rx_used[k], zero-extended to WIDTH.
//   - idx++ on each out handshake.
//   - cmd_done/abort -> DONE; no ring control.
// RDATA:
//   - spi_tx_en=1; out_valid=rx_valid[ch]&&rem!=0; out_data=rx_data[ch].
//   - rx_pop[ch]=out_valid&&out_ready; rem-- on each pop.
//   - cmd_done with rem==0 (including a final pop in the same cycle) -> DONE, rx_commit[ch].
//   - cmd_done with rem!=0, or cmd_abort -> DONE, rx_rollback[ch]; data is kept for retry.
// DONE: exactly 1 cycle. The commit or rollback pulse is asserted here. Return to IDLE; spi_tx_en=0; spi_tx_size=0.
// cmd_valid outside IDLE: ignored; err_busy pulses.
// rst mid-operation: forces IDLE; no commit or rollback is emitted (rings are reset by the same rst).
// All ring-control outputs are one-hot per channel and are registered.
// TESTING
// 1. NCH=2: SEND ch1, payload 3 words 0x1111/2222/3333, cmd_done -> tx_valid[1]x3 with those words, tx_open[1] then tx_commit[1], ch0 untouched.
// 2. SEND ch0, 2 words, cmd_abort -> tx_rollback[0] 1 cycle, tx_commit never.
// 3. STS with tx_used={5,0}, rx_used={7,2} -> spi_tx_size=4; out = 0,2,5,7 for {tx0,rx0,tx1,rx1}.
// 4. RECEIVE_DATA ch0, rx_used=3, out_ready toggling -> 3 pops, out order preserved; cmd_done -> rx_commit[0]; cmd_done after only 2 pops -> rx_rollback[0].
// 5. cmd_addr=0x12 SEND -> no tx activity, payload dropped; TCC_RESET -> reset_request=1 until rst.
// 6. cmd_valid during SEND -> err_busy pulse, SEND continues; rst mid-RDATA -> IDLE next cycle, no commit or rollback.

Source files
------------

// File: rtl/mil_spi_dispatch.sv
// Multi-channel SPI command dispatcher: routes SPI payload into per-channel TX rings,
// streams a status block or RX ring contents back, and wraps ring access in open/commit/rollback.
package mil_spi_dispatch_pkg;
  typedef enum logic [7:0] {
    TCC_UNKNOWN      = 8'h00,
    TCC_RESET        = 8'h01,
    TCC_SEND_DATA    = 8'h02,
    TCC_RECEIVE_STS  = 8'h03,
    TCC_RECEIVE_DATA = 8'h04
  } TCommandCode;
endpackage

module mil_spi_dispatch
  import mil_spi_dispatch_pkg::*;
#(
  parameter logic [7:0]  BLOCK_ADDR = 8'hAB,
  parameter int unsigned NCH        = 2,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  input  logic [7:0]             cmd_addr,
  input  TCommandCode            cmd_code,
  input  logic [CH_W-1:0]        cmd_chan,
  input  logic                   cmd_done,
  input  logic                   cmd_abort,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic [NCH-1:0]         tx_valid,
  input  logic [NCH-1:0]         tx_ready,
  output logic [WIDTH-1:0]       tx_data,
  output logic [NCH-1:0]         tx_open,
  output logic [NCH-1:0]         tx_commit,
  output logic [NCH-1:0]         tx_rollback,
  input  logic [NCH*CNT_W-1:0]   tx_used,
  input  logic [NCH-1:0]         rx_valid,
  input  logic [NCH*WIDTH-1:0]   rx_data,
  output logic [NCH-1:0]         rx_pop,
  output logic [NCH-1:0]         rx_open,
  output logic [NCH-1:0]         rx_commit,
  output logic [NCH-1:0]         rx_rollback,
  input  logic [NCH*CNT_W-1:0]   rx_used,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [CNT_W-1:0]       spi_tx_size,
  output logic                   spi_tx_en,
  output logic                   reset_request,
  output logic                   err_busy
);

  localparam int unsigned IDX_W = $clog2(2 * NCH + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_STS, S_RDATA, S_DONE} state_t;

  state_t            r_state;
  logic [CH_W-1:0]   r_chan;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_tx_size;
  logic [NCH-1:0]    r_tx_open, r_tx_commit, r_tx_rollback;
  logic [NCH-1:0]    r_rx_open, r_rx_commit, r_rx_rollback;
  logic              r_reset_request;
  logic              r_err_busy;

  logic              w_accept;
  logic [NCH-1:0]    w_sel, w_cmd_sel;
  logic              w_tx_rdy, w_rx_vld;
  logic [CNT_W-1:0]  w_cmd_used;
  logic              w_sts_vld;
  logic [IDX_W-1:0]  w_k;
  logic [CNT_W-1:0]  w_sts_word;
  logic              w_rd_vld, w_rd_fire;
  logic [CNT_W-1:0]  w_rem_next;

  assign w_accept   = cmd_valid && (cmd_addr == BLOCK_ADDR) && (32'(cmd_chan) < NCH);
  assign w_sel      = NCH'(1) << r_chan;
  assign w_cmd_sel  = NCH'(1) << cmd_chan;
  assign w_tx_rdy   = |(tx_ready & w_sel);
  assign w_rx_vld   = |(rx_valid & w_sel);
  assign w_cmd_used = rx_used[cmd_chan*CNT_W +: CNT_W];

  // Status block interleaves fill levels per channel: even words TX, odd words RX.
  assign w_sts_vld  = (32'(r_idx) < 2 * NCH);
  assign w_k        = w_sts_vld ? (r_idx >> 1) : '0;
  assign w_sts_word = r_idx[0] ? rx_used[w_k*CNT_W +: CNT_W] : tx_used[w_k*CNT_W +: CNT_W];

  assign w_rd_vld   = (r_state == S_RDATA) && w_rx_vld && (r_rem != '0);
  assign w_rd_fire  = w_rd_vld && out_ready;
  assign w_rem_next = r_rem - CNT_W'(w_rd_fire);

  always_comb begin
    in_ready  = 1'b1;
    tx_valid  = '0;
    tx_data   = '0;
    out_valid = 1'b0;
    out_data  = '0;
    rx_pop    = '0;
    spi_tx_en = 1'b0;
    case (r_state)
      S_SEND: begin
        tx_valid = in_valid ? w_sel : '0;
        in_ready = w_tx_rdy;
        tx_data  = in_data;
      end
      S_STS: begin
        spi_tx_en = 1'b1;
        out_valid = w_sts_vld;
        out_data  = w_sts_vld ? WIDTH'(w_sts_word) : '0;
      end
      S_RDATA: begin
        spi_tx_en = 1'b1;
        out_valid = w_rd_vld;
        out_data  = rx_data[r_chan*WIDTH +: WIDTH];
        rx_pop    = w_rd_fire ? w_sel : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_chan          <= '0;
      r_idx           <= '0;
      r_rem           <= '0;
      r_tx_size       <= '0;
      r_tx_open       <= '0;
      r_tx_commit     <= '0;
      r_tx_rollback   <= '0;
      r_rx_open       <= '0;
      r_rx_commit     <= '0;
      r_rx_rollback   <= '0;
      r_reset_request <= 1'b0;
      r_err_busy      <= 1'b0;
    end else begin
      r_tx_open     <= '0;
      r_tx_commit   <= '0;
      r_tx_rollback <= '0;
      r_rx_open     <= '0;
      r_rx_commit   <= '0;
      r_rx_rollback <= '0;
      r_err_busy    <= cmd_valid && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_chan <= cmd_chan;
            case (cmd_code)
              TCC_RESET: r_reset_request <= 1'b1;
              TCC_SEND_DATA: begin
                r_state   <= S_SEND;
                r_tx_open <= w_cmd_sel;
              end
              TCC_RECEIVE_STS: begin
                r_state   <= S_STS;
                r_tx_size <= CNT_W'(2 * NCH);
                r_idx     <= '0;
              end
              TCC_RECEIVE_DATA: begin
                r_state   <= S_RDATA;
                r_rem     <= w_cmd_used;
                r_tx_size <= w_cmd_used;
                r_rx_open <= w_cmd_sel;
              end
              default: ;
            endcase
          end
        end
        S_SEND: begin
          if (cmd_done) begin
            r_state     <= S_DONE;
            r_tx_commit <= w_sel;
          end else if (cmd_abort) begin
            r_state       <= S_DONE;
            r_tx_rollback <= w_sel;
          end
        end
        S_STS: begin
          if (w_sts_vld && out_ready) r_idx <= r_idx + 1'b1;
          if (cmd_done || cmd_abort) begin
            r_state   <= S_DONE;
            r_tx_size <= '0;
          end
        end
        S_RDATA: begin
          r_rem <= w_rem_next;
          // Commit only when the whole sampled count left, counting a pop on the done cycle.
          if (cmd_done || cmd_abort) begin
            r_state   <= S_DONE;
            r_tx_size <= '0;
            if (cmd_done && (w_rem_next == '0)) r_rx_commit <= w_sel;
            else r_rx_rollback <= w_sel;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_open       = r_tx_open;
  assign tx_commit     = r_tx_commit;
  assign tx_rollback   = r_tx_rollback;
  assign rx_open       = r_rx_open;
  assign rx_commit     = r_rx_commit;
  assign rx_rollback   = r_rx_rollback;
  assign spi_tx_size   = r_tx_size;
  assign reset_request = r_reset_request;
  assign err_busy      = r_err_busy;

endmodule

// File: tb/tb_mil_spi_dispatch.sv
// Randomized bench for mil_spi_dispatch: a transaction-level model of rings and SPI
// streams predicts every output cycle by cycle.
module tb_mil_spi_dispatch;
  import mil_spi_dispatch_pkg::*;

  localparam int NCH = 2;
  localparam int WIDTH = 16;
  localparam int CNT_W = 16;

  logic clk, rst;
  logic cmd_valid, cmd_done, cmd_abort;
  logic [7:0] cmd_addr;
  TCommandCode cmd_code;
  logic [0:0] cmd_chan;
  logic in_valid, in_ready;
  logic [WIDTH-1:0] in_data, tx_data, out_data;
  logic [NCH-1:0] tx_valid, tx_ready, tx_open, tx_commit, tx_rollback;
  logic [NCH-1:0] rx_valid, rx_pop, rx_open, rx_commit, rx_rollback;
  logic [NCH*CNT_W-1:0] tx_used, rx_used;
  logic [NCH*WIDTH-1:0] rx_data;
  logic out_valid, out_ready, spi_tx_en, reset_request, err_busy;
  logic [CNT_W-1:0] spi_tx_size;

  mil_spi_dispatch #(.BLOCK_ADDR(8'hAB), .NCH(NCH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_code(cmd_code),
    .cmd_chan(cmd_chan), .cmd_done(cmd_done), .cmd_abort(cmd_abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_open(tx_open), .tx_commit(tx_commit), .tx_rollback(tx_rollback), .tx_used(tx_used),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_pop(rx_pop),
    .rx_open(rx_open), .rx_commit(rx_commit), .rx_rollback(rx_rollback), .rx_used(rx_used),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .spi_tx_size(spi_tx_size), .spi_tx_en(spi_tx_en),
    .reset_request(reset_request), .err_busy(err_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [16:0] tx_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    cmd_valid = 1'b0; cmd_done = 1'b0; cmd_abort = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; rx_valid = '0;
  endtask

  task automatic issue(input logic [7:0] addr, input TCommandCode code, input int ch);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_code = code; cmd_chan = 1'(ch);
    #1;
    next_cycle;
    cmd_valid = 1'b0;
  endtask

  task automatic send_txn(input int ch, input int n, input bit abort, input bit busy, input bit fixed);
    logic [WIDTH-1:0] words[$];
    int idx, cyc;
    bit v, hs;
    logic [1:0] r;
    int sel;
    sel = 1 << ch;
    for (int i = 0; i < n; i++) words.push_back(fixed ? WIDTH'((i + 1) * 16'h1111) : WIDTH'($urandom));
    tx_log.delete();
    issue(8'hAB, TCC_SEND_DATA, ch);
    idx = 0; cyc = 0;
    while (idx < n && cyc < 300) begin
      v = ($urandom_range(0, 3) != 0);
      r = 2'($urandom_range(0, 3));
      hs = v && r[ch];
      in_valid = v; in_data = words[idx]; tx_ready = r;
      cmd_done = hs && (idx == n - 1) && !abort;
      cmd_abort = hs && (idx == n - 1) && abort;
      cmd_valid = busy && (cyc == 1);
      #1;
      check("send_open", tx_open, (cyc == 0) ? sel : 0);
      check("send_txvalid", tx_valid, v ? sel : 0);
      check("send_inready", in_ready, r[ch]);
      if (v) check("send_txdata", tx_data, words[idx]);
      check("send_errbusy", err_busy, busy && (cyc == 2));
      check("send_ctl_idle", {tx_commit, tx_rollback}, 0);
      for (int c = 0; c < NCH; c++)
        if (tx_valid[c] && tx_ready[c]) tx_log.push_back({1'(c), tx_data});
      if (hs) idx++;
      cyc++;
      next_cycle;
    end
    if (idx < n) check("send_timeout", idx, n);
    clear_inputs();
    #1;
    check("send_commit", tx_commit, abort ? 0 : sel);
    check("send_rollback", tx_rollback, abort ? sel : 0);
    check("send_done_inready", in_ready, 1);
    next_cycle;
    check("send_after_ctl", {tx_commit, tx_rollback, tx_open}, 0);
    check("send_count", tx_log.size(), n);
    for (int i = 0; i < n && i < tx_log.size(); i++)
      check("send_word", tx_log[i], {1'(ch), words[i]});
  endtask

  task automatic sts_txn(input logic [31:0] tu, input logic [31:0] ru, input bit abort);
    logic [WIDTH-1:0] exp[4];
    int k, cyc;
    for (int i = 0; i < 4; i++) exp[i] = (i % 2 == 0) ? WIDTH'(tu >> (16 * (i / 2))) : WIDTH'(ru >> (16 * (i / 2)));
    tx_used = tu; rx_used = ru;
    issue(8'hAB, TCC_RECEIVE_STS, $urandom_range(0, 1));
    k = 0; cyc = 0;
    while (k < 4 && cyc < 100) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      check("sts_size", spi_tx_size, 2 * NCH);
      check("sts_en", spi_tx_en, 1);
      check("sts_valid", out_valid, 1);
      check("sts_data", out_data, exp[k]);
      if (out_ready) k++;
      cyc++;
      next_cycle;
    end
    if (k < 4) check("sts_timeout", k, 4);
    out_ready = 1'b1;
    if (abort) cmd_abort = 1'b1; else cmd_done = 1'b1;
    #1;
    check("sts_drained", out_valid, 0);
    next_cycle;
    clear_inputs();
    #1;
    check("sts_done_size", spi_tx_size, 0);
    check("sts_done_en", spi_tx_en, 0);
    check("sts_done_ctl", {tx_commit, tx_rollback, rx_commit, rx_rollback}, 0);
    next_cycle;
  endtask

  task automatic rdata_txn(input int ch, input int n, input int target, input bit abort, input bit same);
    logic [WIDTH-1:0] q[$];
    int ptr, cyc, sel;
    bit rv, rdy, ov, hs, fin, done_sent, commit;
    sel = 1 << ch;
    for (int i = 0; i < n; i++) q.push_back(WIDTH'($urandom));
    rx_used = {16'($urandom), 16'($urandom)};
    rx_used[ch*CNT_W +: CNT_W] = CNT_W'(n);
    issue(8'hAB, TCC_RECEIVE_DATA, ch);
    ptr = 0; cyc = 0; done_sent = 0;
    while (!done_sent && cyc < 300) begin
      rv = (ptr < n) && ($urandom_range(0, 3) != 0);
      rdy = (ptr < target) && ((cyc % 2 == 1) || ($urandom_range(0, 1) == 1));
      rx_valid = 2'($urandom_range(0, 3));
      rx_valid[ch] = rv;
      rx_data = {16'($urandom), 16'($urandom)};
      if (ptr < n) rx_data[ch*WIDTH +: WIDTH] = q[ptr];
      out_ready = rdy;
      ov = rv;
      hs = ov && rdy;
      fin = same ? (ptr + int'(hs) == target) : (ptr == target);
      cmd_done = fin && !abort;
      cmd_abort = fin && abort;
      #1;
      check("rd_open", rx_open, (cyc == 0) ? sel : 0);
      check("rd_size", spi_tx_size, n);
      check("rd_en", spi_tx_en, 1);
      check("rd_valid", out_valid, ov);
      if (ov) check("rd_data", out_data, q[ptr]);
      check("rd_pop", rx_pop, hs ? sel : 0);
      if (hs) ptr++;
      if (fin) done_sent = 1;
      cyc++;
      next_cycle;
    end
    if (!done_sent) check("rd_timeout", ptr, target);
    clear_inputs();
    #1;
    commit = (target == n) && !abort;
    check("rd_commit", rx_commit, commit ? sel : 0);
    check("rd_rollback", rx_rollback, commit ? 0 : sel);
    check("rd_done_size", spi_tx_size, 0);
    check("rd_done_valid", out_valid, 0);
    next_cycle;
    check("rd_after_ctl", {rx_commit, rx_rollback}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n;
    rst = 1'b1;
    clear_inputs();
    cmd_addr = 8'h00; cmd_code = TCC_UNKNOWN; cmd_chan = '0;
    in_data = '0; tx_ready = '0; tx_used = '0; rx_used = '0; rx_data = '0;
    repeat (3) next_cycle;
    check("rst_inready", in_ready, 1);
    check("rst_outs", {out_valid, spi_tx_en, reset_request, err_busy, tx_valid, rx_pop}, 0);
    check("rst_ctl", {tx_open, tx_commit, tx_rollback, rx_open, rx_commit, rx_rollback}, 0);
    check("rst_size", spi_tx_size, 0);
    rst = 1'b0;
    next_cycle;

    send_txn(1, 3, 0, 0, 1);
    send_txn(0, 2, 1, 0, 0);
    sts_txn({16'd5, 16'd0}, {16'd7, 16'd2}, 0);
    rdata_txn(0, 3, 3, 0, 0);
    rdata_txn(0, 3, 2, 0, 0);
    rdata_txn(1, 4, 4, 0, 1);
    rdata_txn(1, 0, 0, 0, 0);

    // Foreign address and unknown code are dropped in IDLE.
    issue(8'h12, TCC_SEND_DATA, 0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; tx_ready = 2'b11; in_data = 16'($urandom);
      #1;
      check("foreign_txvalid", tx_valid, 0);
      check("foreign_inready", in_ready, 1);
      check("foreign_open", tx_open, 0);
      next_cycle;
    end
    in_valid = 1'b0;
    issue(8'hAB, TCommandCode'(8'h55), 1);
    #1;
    check("unknown_en", spi_tx_en, 0);
    check("unknown_ctl", {tx_open, rx_open}, 0);
    check("pre_resetreq", reset_request, 0);
    issue(8'hAB, TCC_RESET, 0);
    for (int i = 0; i < 4; i++) begin
      check("reset_request_sticky", reset_request, 1);
      next_cycle;
    end

    send_txn(0, 4, 0, 1, 0);

    // Reset in the middle of an RDATA transfer.
    rx_used = {16'd4, 16'd4};
    issue(8'hAB, TCC_RECEIVE_DATA, 1);
    rx_valid = 2'b11; out_ready = 1'b1;
    next_cycle;
    next_cycle;
    rst = 1'b1;
    next_cycle;
    rst = 1'b0;
    clear_inputs();
    #1;
    check("rstmid_state", {out_valid, spi_tx_en}, 0);
    check("rstmid_ctl", {rx_commit, rx_rollback, tx_commit, tx_rollback}, 0);
    check("rstmid_size", spi_tx_size, 0);
    check("rstmid_resetreq", reset_request, 0);
    check("rstmid_inready", in_ready, 1);
    next_cycle;
    check("rstmid_ctl_later", {rx_commit, rx_rollback}, 0);

    for (int it = 0; it < 24; it++) begin
      t = $urandom_range(0, 2);
      case (t)
        0: send_txn($urandom_range(0, 1), $urandom_range(3, 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        1: sts_txn($urandom, $urandom, 1'($urandom_range(0, 1)));
        default: begin
          n = $urandom_range(0, 6);
          rdata_txn($urandom_range(0, 1), n, $urandom_range(0, n), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
